iob_fifo_sync_fwft: RTL and testbench

Synchronous single-clock FIFO, successor to the basic synchronous FIFO: adds a first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. Storage is an external synchronous RAM with one-cycle read latency, driven through the standard `ext_mem_*` port set. It sits between stream producers and consumers in the cache and memory datapaths.

---
 rtl/iob_fifo_sync_fwft.sv | 200 ++++++++++++++++++++
 tb/tb_iob_fifo_sync_fwft.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fifo_sync_fwft.sv
// iob_fifo_sync_fwft
// Single-clock FIFO built around an external synchronous RAM (one-cycle read
// latency). Provides a standard read mode and a first-word-fall-through mode,
// threshold flags and sticky overflow/underflow flags.
//
// Ports
//   clk_i, cke_i, rst_i         clock, clock enable, synchronous active-high reset
//   w_en_i, w_data_i            write request and data
//   w_full_o, w_afull_o         full / almost-full (level >= AFULL_TH)
//   r_en_i                      read request (pop/acknowledge in FWFT mode)
//   r_data_o, r_valid_o         read data and its valid
//   r_empty_o, r_aempty_o       empty / almost-empty (level <= AEMPTY_TH)
//   level_o                     words held (RAM + in-flight + output buffer)
//   overflow_o, underflow_o     sticky error flags, cleared only by reset
//   ext_mem_*                   external RAM port set
module iob_fifo_sync_fwft #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned FWFT      = 1,
   parameter int unsigned AFULL_TH  = 2**ADDR_W - 2,
   parameter int unsigned AEMPTY_TH = 2
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              rst_i,

   input  logic              w_en_i,
   input  logic [DATA_W-1:0] w_data_i,
   output logic              w_full_o,
   output logic              w_afull_o,

   input  logic              r_en_i,
   output logic [DATA_W-1:0] r_data_o,
   output logic              r_valid_o,
   output logic              r_empty_o,
   output logic              r_aempty_o,

   output logic [ADDR_W:0]   level_o,
   output logic              overflow_o,
   output logic              underflow_o,

   output logic              ext_mem_clk_o,
   output logic              ext_mem_w_en_o,
   output logic [ADDR_W-1:0] ext_mem_w_addr_o,
   output logic [DATA_W-1:0] ext_mem_w_data_o,
   output logic              ext_mem_r_en_o,
   output logic [ADDR_W-1:0] ext_mem_r_addr_o,
   input  logic [DATA_W-1:0] ext_mem_r_data_i
);

   localparam int unsigned LVL_W   = ADDR_W + 1;
   localparam int unsigned DEPTH   = 2**ADDR_W;
   localparam bit          FWFT_EN = (FWFT != 0);

   // State
   logic [ADDR_W-1:0] w_ptr;
   logic [ADDR_W-1:0] r_ptr;
   logic [LVL_W-1:0]  level;
   logic [LVL_W-1:0]  mem_cnt;     // words in RAM not yet fetched (FWFT)
   logic [1:0]        buf_cnt;     // output buffer occupancy (FWFT)
   logic [DATA_W-1:0] buf0;
   logic [DATA_W-1:0] buf1;
   logic              inflight;    // RAM read issued last enabled cycle (FWFT)
   logic              valid;
   logic              empty;
   logic              full;
   logic              afull;
   logic              aempty;
   logic              ovf;
   logic              udf;

   // Next-state / handshake signals
   logic              w_int;
   logic              r_int;
   logic              pop;
   logic              rd_acc;
   logic              prefetch;
   logic              rd_issue;
   logic [1:0]        held;
   logic [1:0]        after_pop;
   logic [DATA_W-1:0] head0;
   logic [DATA_W-1:0] head1;
   logic [DATA_W-1:0] buf0_nxt;
   logic [DATA_W-1:0] buf1_nxt;
   logic [1:0]        buf_cnt_nxt;
   logic [LVL_W-1:0]  mem_cnt_nxt;
   logic [LVL_W-1:0]  level_nxt;
   logic              valid_nxt;
   logic              empty_nxt;
   logic              full_nxt;
   logic              afull_nxt;
   logic              aempty_nxt;

   // Handshakes, prefetch decision, buffer shuffle and next level
   always_comb begin
      w_int     = w_en_i & ~full;
      r_int     = r_en_i & ~empty;
      pop       = FWFT_EN & r_en_i & valid;
      rd_acc    = FWFT_EN ? pop : r_int;

      // Words visible to the consumer: buffer entries plus the one arriving
      // from RAM this cycle. Prefetch keeps this at most two after the pop.
      held      = 2'(buf_cnt + 2'(inflight));
      after_pop = held - 2'(pop);
      prefetch  = FWFT_EN && (mem_cnt != '0) && (after_pop < 2'd2);
      rd_issue  = FWFT_EN ? prefetch : r_int;

      // Ordered candidates: stored entries first, then the arriving RAM word
      head0     = (buf_cnt != 2'd0) ? buf0 : ext_mem_r_data_i;
      head1     = (buf_cnt == 2'd2) ? buf1 : ext_mem_r_data_i;
      buf0_nxt  = pop ? head1 : head0;
      buf1_nxt  = pop ? ext_mem_r_data_i : head1;
      buf_cnt_nxt = FWFT_EN ? after_pop : 2'd0;

      mem_cnt_nxt = '0;
      if (FWFT_EN) begin
         mem_cnt_nxt = mem_cnt + LVL_W'(w_int) - LVL_W'(prefetch);
      end

      level_nxt = level + LVL_W'(w_int) - LVL_W'(rd_acc);

      if (FWFT_EN) begin
         valid_nxt = (after_pop != 2'd0) | prefetch;
         empty_nxt = ~valid_nxt;
      end else begin
         valid_nxt = r_int;
         empty_nxt = (level_nxt == '0);
      end

      full_nxt   = (level_nxt == LVL_W'(DEPTH));
      // level >= TH written as level + 1 > TH so TH = 0 is not a constant compare
      afull_nxt  = (({1'b0, level_nxt} + (LVL_W+1)'(1)) > (LVL_W+1)'(AFULL_TH));
      aempty_nxt = (level_nxt <= LVL_W'(AEMPTY_TH));
   end

   // State register; reset wins over the clock enable
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_ptr    <= '0;
         r_ptr    <= '0;
         level    <= '0;
         mem_cnt  <= '0;
         buf_cnt  <= '0;
         buf0     <= '0;
         buf1     <= '0;
         inflight <= 1'b0;
         valid    <= 1'b0;
         empty    <= 1'b1;
         full     <= 1'b0;
         afull    <= (AFULL_TH == 0);
         aempty   <= 1'b1;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else if (cke_i) begin
         if (w_int) begin
            w_ptr <= w_ptr + ADDR_W'(1);
         end
         if (rd_issue) begin
            r_ptr <= r_ptr + ADDR_W'(1);
         end
         level    <= level_nxt;
         mem_cnt  <= mem_cnt_nxt;
         buf_cnt  <= buf_cnt_nxt;
         buf0     <= buf0_nxt;
         buf1     <= buf1_nxt;
         inflight <= prefetch;
         valid    <= valid_nxt;
         empty    <= empty_nxt;
         full     <= full_nxt;
         afull    <= afull_nxt;
         aempty   <= aempty_nxt;
         if (w_en_i & full) begin
            ovf <= 1'b1;
         end
         if (r_en_i & empty) begin
            udf <= 1'b1;
         end
      end
   end

   // RAM port: requests are suppressed while halted or in reset
   assign ext_mem_clk_o    = clk_i;
   assign ext_mem_w_en_o   = cke_i & ~rst_i & w_int;
   assign ext_mem_w_addr_o = w_ptr;
   assign ext_mem_w_data_o = w_data_i;
   assign ext_mem_r_en_o   = cke_i & ~rst_i & rd_issue;
   assign ext_mem_r_addr_o = r_ptr;

   // User-facing outputs
   assign r_data_o    = FWFT_EN ? head0 : ext_mem_r_data_i;
   assign r_valid_o   = valid;
   assign r_empty_o   = empty;
   assign r_aempty_o  = aempty;
   assign w_full_o    = full;
   assign w_afull_o   = afull;
   assign level_o     = level;
   assign overflow_o  = ovf;
   assign underflow_o = udf;

endmodule

// File: tb/tb_iob_fifo_sync_fwft.sv
// Testbench for iob_fifo_sync_fwft: three instances share stimulus
// (0: standard mode, 1: FWFT, 2: FWFT with AFULL_TH = 0). A queue-based model
// of the selected instance predicts every output each cycle.
module tb_iob_fifo_sync_fwft;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AF    = 14;
   localparam int unsigned AE    = 2;

   logic          clk = 1'b0;
   logic          cke;
   logic          rst;
   logic          w_en;
   logic          r_en;
   logic [DW-1:0] w_data;

   logic          wfull   [3];
   logic          wafull  [3];
   logic [DW-1:0] rdata   [3];
   logic          rvalid  [3];
   logic          rempty  [3];
   logic          raempty [3];
   logic [AW:0]   lvl     [3];
   logic          ovf     [3];
   logic          udf     [3];
   logic          mclk    [3];
   logic          mwen    [3];
   logic [AW-1:0] mwaddr  [3];
   logic [DW-1:0] mwdata  [3];
   logic          mren    [3];
   logic [AW-1:0] mraddr  [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [DW-1:0] ram [DEPTH];
      logic [DW-1:0] rq;

      iob_fifo_sync_fwft #(
         .DATA_W    (DW),
         .ADDR_W    (AW),
         .FWFT      ((g == 0) ? 0 : 1),
         .AFULL_TH  ((g == 2) ? 0 : AF),
         .AEMPTY_TH (AE)
      ) u_dut (
         .clk_i            (clk),
         .cke_i            (cke),
         .rst_i            (rst),
         .w_en_i           (w_en),
         .w_data_i         (w_data),
         .w_full_o         (wfull[g]),
         .w_afull_o        (wafull[g]),
         .r_en_i           (r_en),
         .r_data_o         (rdata[g]),
         .r_valid_o        (rvalid[g]),
         .r_empty_o        (rempty[g]),
         .r_aempty_o       (raempty[g]),
         .level_o          (lvl[g]),
         .overflow_o       (ovf[g]),
         .underflow_o      (udf[g]),
         .ext_mem_clk_o    (mclk[g]),
         .ext_mem_w_en_o   (mwen[g]),
         .ext_mem_w_addr_o (mwaddr[g]),
         .ext_mem_w_data_o (mwdata[g]),
         .ext_mem_r_en_o   (mren[g]),
         .ext_mem_r_addr_o (mraddr[g]),
         .ext_mem_r_data_i (rq)
      );

      // Synchronous RAM, one-cycle read latency, output held when not reading
      always_ff @(posedge mclk[g]) begin
         if (mwen[g]) ram[mwaddr[g]] <= mwdata[g];
         if (mren[g]) rq <= ram[mraddr[g]];
      end
   end

   // Reference model: queue of (data, enabled-cycle of write)
   typedef struct {
      logic [DW-1:0] d;
      int            t;
   } ent_t;

   ent_t          q[$];
   int            cyc;
   int            mode;
   int            idx;
   bit            chk;
   bit            m_ovf;
   bit            m_udf;
   bit            m_pv;
   logic [DW-1:0] m_pd;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // FWFT: the head word is presented two enabled cycles after its write.
   // Standard: valid follows an accepted read by one cycle.
   function automatic bit exp_valid();
      if (mode != 0) return (q.size() > 0) && (cyc >= q[0].t + 2);
      return m_pv;
   endfunction

   task automatic compare();
      int sz;
      bit v;
      bit e;
      sz = q.size();
      v  = exp_valid();
      e  = (mode != 0) ? !v : (sz == 0);
      check($sformatf("level m%0d c%0d", mode, cyc), 32'(lvl[idx]), sz);
      check($sformatf("full m%0d c%0d", mode, cyc), 32'(wfull[idx]), 32'(sz == DEPTH));
      check($sformatf("afull m%0d c%0d", mode, cyc), 32'(wafull[idx]), 32'(sz >= AF));
      check($sformatf("aempty m%0d c%0d", mode, cyc), 32'(raempty[idx]), 32'(sz <= AE));
      check($sformatf("empty m%0d c%0d", mode, cyc), 32'(rempty[idx]), 32'(e));
      check($sformatf("valid m%0d c%0d", mode, cyc), 32'(rvalid[idx]), 32'(v));
      check($sformatf("ovf m%0d c%0d", mode, cyc), 32'(ovf[idx]), 32'(m_ovf));
      check($sformatf("udf m%0d c%0d", mode, cyc), 32'(udf[idx]), 32'(m_udf));
      if (v) begin
         check($sformatf("data m%0d c%0d", mode, cyc), rdata[idx],
               (mode != 0) ? q[0].d : m_pd);
      end
   endtask

   // One clock cycle: drive, check current outputs, advance model, clock
   task automatic step(input bit we, input logic [DW-1:0] wd, input bit re);
      int sz;
      bit v;
      bit e;
      bit fl;
      bit pop;
      w_en   = we;
      w_data = wd;
      r_en   = re;
      #1;
      if (chk) compare();
      if (cke) begin
         sz  = q.size();
         v   = exp_valid();
         e   = (mode != 0) ? !v : (sz == 0);
         fl  = (sz == DEPTH);
         pop = re && !e;
         if (we && fl) m_ovf = 1'b1;
         if (re && e) m_udf = 1'b1;
         if (mode == 0) m_pv = pop;
         if (pop) begin
            m_pd = q[0].d;
            void'(q.pop_front());
         end
         if (we && !fl) q.push_back('{d: wd, t: cyc});
         cyc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit ck);
      cke  = ck;
      rst  = 1'b1;
      w_en = 1'b0;
      r_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cke = 1'b1;
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_pv  = 1'b0;
   endtask

   task automatic check_reset();
      for (int g = 0; g < 3; g++) begin
         check($sformatf("rst empty %0d", g), 32'(rempty[g]), 1);
         check($sformatf("rst aempty %0d", g), 32'(raempty[g]), 1);
         check($sformatf("rst full %0d", g), 32'(wfull[g]), 0);
         check($sformatf("rst afull %0d", g), 32'(wafull[g]), 32'(g == 2));
         check($sformatf("rst valid %0d", g), 32'(rvalid[g]), 0);
         check($sformatf("rst level %0d", g), 32'(lvl[g]), 0);
         check($sformatf("rst ovf %0d", g), 32'(ovf[g]), 0);
         check($sformatf("rst udf %0d", g), 32'(udf[g]), 0);
      end
   endtask

   initial begin
      cyc = 0; mode = 0; idx = 0; chk = 1'b1;
      m_pd = '0; w_data = '0;
      do_reset(1'b1);
      check_reset();

      // Standard mode: fill, overflow, drain, underflow
      mode = 0; idx = 0;
      for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0);
      step(1'b1, 32'h99, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      // Standard mode: read+write at full, then steady
      do_reset(1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, DW'(32'h100 + i), 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, DW'(32'h200 + i), 1'b1);
      step(1'b0, '0, 1'b0);

      // FWFT: latency of a single word, then burst with r_en held
      mode = 1; idx = 1;
      do_reset(1'b1);
      step(1'b1, 32'hA5, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, DW'(32'h300 + i), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);

      // FWFT: write + read at empty, then fill and read+write at full
      do_reset(1'b1);
      step(1'b1, 32'h55, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, DW'(32'h400 + i), 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, DW'(32'h500 + i), 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);

      // Random streams with clock-enable gaps, both modes
      for (int m = 0; m < 2; m++) begin
         mode = m; idx = m;
         do_reset(1'b1);
         for (int j = 0; j < 400; j++) begin
            int wp;
            wp  = (((j / 50) % 2) == 0) ? 75 : 30;
            cke = ($urandom_range(0, 7) != 0);
            step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < (100 - wp));
         end
         cke = 1'b1;
         for (int j = 0; j < 40; j++) step(1'b0, '0, 1'b1);
      end

      // FWFT: reset with clock enable low while a RAM read is in flight
      mode = 1; idx = 1;
      do_reset(1'b1);
      step(1'b1, 32'h1234, 1'b0);
      step(1'b0, '0, 1'b0);
      do_reset(1'b0);
      check_reset();
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
      step(1'b1, 32'h77, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
